// File: rtl/lsu_dcache_arbiter.sv
// Arbitrates load issue and store drain onto the single D-cache request port,
// and routes in-order load responses back to their LDQ entry.
module lsu_dcache_arbiter #(
    parameter int LDQ_IDX_W    = 4,
    parameter int SDQ_CNT_W    = 4,
    parameter int DRAIN_HI     = 6,
    parameter int DRAIN_LO     = 2,
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_OUTST    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ld_vld,
    output logic                 ld_rdy,
    input  logic [LDQ_IDX_W-1:0] ld_ldq_idx,
    input  logic [31:0]          ld_addr,
    input  logic                 st_vld,
    output logic                 st_rdy,
    input  logic [31:0]          st_addr,
    input  logic [31:0]          st_data,
    input  logic [3:0]           st_be,
    input  logic [SDQ_CNT_W-1:0] sdq_count,
    input  logic                 flush,
    output logic                 dc_req_vld,
    input  logic                 dc_req_rdy,
    output logic                 dc_req_we,
    output logic [31:0]          dc_req_addr,
    output logic [31:0]          dc_req_wdata,
    output logic [3:0]           dc_req_be,
    input  logic                 dc_rsp_vld,
    input  logic [31:0]          dc_rsp_data,
    output logic                 ld_rsp_vld,
    output logic [LDQ_IDX_W-1:0] ld_rsp_ldq_idx,
    output logic [31:0]          ld_rsp_data
);

    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {NORMAL, DRAIN} mode_t;

    mode_t                r_mode;
    logic [STV_W-1:0]     r_starve;
    logic                 r_req_vld;
    logic                 r_req_we;
    logic [31:0]          r_req_addr;
    logic [31:0]          r_req_wdata;
    logic [3:0]           r_req_be;
    logic [LDQ_IDX_W-1:0] r_tag_idx [MAX_OUTST];
    logic [MAX_OUTST-1:0] r_tag_kill;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_cnt;

    logic w_slot_free;
    logic w_pop;
    logic w_load_ok;
    logic w_st_prio;
    logic w_ld_grant;
    logic w_st_grant;
    logic w_enter_drain;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_slot_free   = !r_req_vld || dc_req_rdy;
    assign w_pop         = dc_rsp_vld && (r_cnt != '0);
    // A same-cycle pop frees a tag slot, so a full FIFO still accepts a load.
    assign w_load_ok     = w_slot_free && !flush && ((r_cnt < CNT_W'(MAX_OUTST)) || w_pop);
    assign w_st_prio     = (r_mode == DRAIN) || (r_starve == STV_W'(STARVE_LIMIT));
    assign w_ld_grant    = rst_n && ld_vld && w_load_ok && !(w_st_prio && st_vld && w_slot_free);
    assign w_st_grant    = rst_n && st_vld && w_slot_free && !w_ld_grant;
    assign w_enter_drain = (r_mode == NORMAL) && (sdq_count >= SDQ_CNT_W'(DRAIN_HI));

    assign ld_rdy         = w_ld_grant;
    assign st_rdy         = w_st_grant;
    assign dc_req_vld     = r_req_vld;
    assign dc_req_we      = r_req_we;
    assign dc_req_addr    = r_req_addr;
    assign dc_req_wdata   = r_req_wdata;
    assign dc_req_be      = r_req_be;
    assign ld_rsp_vld     = w_pop && !r_tag_kill[r_rd_ptr] && !flush;
    assign ld_rsp_ldq_idx = r_tag_idx[r_rd_ptr];
    assign ld_rsp_data    = dc_rsp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= NORMAL;
            r_starve <= '0;
        end else begin
            case (r_mode)
                NORMAL: if (w_enter_drain) r_mode <= DRAIN;
                DRAIN:  if (sdq_count <= SDQ_CNT_W'(DRAIN_LO)) r_mode <= NORMAL;
                default: r_mode <= NORMAL;
            endcase
            if (w_st_grant || w_enter_drain)
                r_starve <= '0;
            else if ((r_mode == NORMAL) && st_vld && (r_starve != STV_W'(STARVE_LIMIT)))
                r_starve <= r_starve + 1'b1;
        end
    end

    // Request slot: fields change only when the slot is free to reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_vld   <= 1'b0;
            r_req_we    <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_be    <= '0;
        end else if (w_slot_free) begin
            r_req_vld <= w_ld_grant || w_st_grant;
            if (w_ld_grant) begin
                r_req_we    <= 1'b0;
                r_req_addr  <= ld_addr;
                r_req_wdata <= '0;
                r_req_be    <= 4'hF;
            end else if (w_st_grant) begin
                r_req_we    <= 1'b1;
                r_req_addr  <= st_addr;
                r_req_wdata <= st_data;
                r_req_be    <= st_be;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_tag_kill <= '0;
            for (int i = 0; i < MAX_OUTST; i++) r_tag_idx[i] <= '0;
        end else begin
            if (flush) r_tag_kill <= '1;
            if (w_ld_grant) begin
                r_tag_idx[r_wr_ptr]  <= ld_ldq_idx;
                r_tag_kill[r_wr_ptr] <= 1'b0;
                r_wr_ptr             <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_ld_grant, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dcache_arbiter.sv
// Directed bench for lsu_dcache_arbiter with hand-computed expectations.
module tb_lsu_dcache_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ld_vld;
    logic        ld_rdy;
    logic [3:0]  ld_ldq_idx;
    logic [31:0] ld_addr;
    logic        st_vld;
    logic        st_rdy;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic [3:0]  sdq_count;
    logic        flush;
    logic        dc_req_vld;
    logic        dc_req_rdy;
    logic        dc_req_we;
    logic [31:0] dc_req_addr;
    logic [31:0] dc_req_wdata;
    logic [3:0]  dc_req_be;
    logic        dc_rsp_vld;
    logic [31:0] dc_rsp_data;
    logic        ld_rsp_vld;
    logic [3:0]  ld_rsp_ldq_idx;
    logic [31:0] ld_rsp_data;

    int n_chk  = 0;
    int n_pass = 0;

    lsu_dcache_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_ldq_idx(ld_ldq_idx), .ld_addr(ld_addr),
        .st_vld(st_vld), .st_rdy(st_rdy), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .sdq_count(sdq_count), .flush(flush),
        .dc_req_vld(dc_req_vld), .dc_req_rdy(dc_req_rdy), .dc_req_we(dc_req_we),
        .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata), .dc_req_be(dc_req_be),
        .dc_rsp_vld(dc_rsp_vld), .dc_rsp_data(dc_rsp_data),
        .ld_rsp_vld(ld_rsp_vld), .ld_rsp_ldq_idx(ld_rsp_ldq_idx), .ld_rsp_data(ld_rsp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ld_vld = 1'b0; ld_ldq_idx = '0; ld_addr = '0;
        st_vld = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
        sdq_count = 4'd0; flush = 1'b0; dc_req_rdy = 1'b1;
        dc_rsp_vld = 1'b0; dc_rsp_data = '0;
        cyc(); cyc();
        ld_vld = 1'b1; st_vld = 1'b1; dc_rsp_vld = 1'b1;
        #1;
        chk("rst_ld_rdy", 32'(ld_rdy), 0);
        chk("rst_st_rdy", 32'(st_rdy), 0);
        chk("rst_req_vld", 32'(dc_req_vld), 0);
        chk("rst_req_addr", dc_req_addr, 0);
        chk("rst_req_be", 32'(dc_req_be), 0);
        chk("rst_rsp_vld", 32'(ld_rsp_vld), 0);
        ld_vld = 1'b0; st_vld = 1'b0; dc_rsp_vld = 1'b0;
        cyc();
        rst_n = 1'b1;

        // basic load and response
        cyc();
        sdq_count = 4'd1; ld_vld = 1'b1; ld_ldq_idx = 4'd15; ld_addr = 32'd5108;
        #1 chk("t1_ld_rdy", 32'(ld_rdy), 1);
        cyc();
        ld_vld = 1'b0;
        #1;
        chk("t1_req_vld", 32'(dc_req_vld), 1);
        chk("t1_req_we", 32'(dc_req_we), 0);
        chk("t1_req_addr", dc_req_addr, 32'd5108);
        chk("t1_req_be", 32'(dc_req_be), 32'hF);
        chk("t1_req_wdata", dc_req_wdata, 0);
        dc_rsp_vld = 1'b1; dc_rsp_data = 32'hCAFE;
        #1;
        chk("t1_rsp_vld", 32'(ld_rsp_vld), 1);
        chk("t1_rsp_idx", 32'(ld_rsp_ldq_idx), 15);
        chk("t1_rsp_data", ld_rsp_data, 32'hCAFE);
        cyc();
        dc_rsp_vld = 1'b0;

        // starvation guard: 8 load wins, then one forced store
        for (int i = 0; i < 10; i++) begin
            cyc();
            ld_vld = 1'b1; st_vld = 1'b1; ld_ldq_idx = 4'(i); ld_addr = 32'h1000 + 32'(i);
            st_addr = 32'h2000; st_data = 32'hA5A5; st_be = 4'hF;
            dc_rsp_vld = (i >= 1 && i <= 8); dc_rsp_data = 32'(i);
            #1;
            chk($sformatf("t2_ld_rdy_%0d", i), 32'(ld_rdy), (i == 8) ? 0 : 1);
            chk($sformatf("t2_st_rdy_%0d", i), 32'(st_rdy), (i == 8) ? 1 : 0);
            if (i >= 1 && i <= 8) chk($sformatf("t2_rsp_idx_%0d", i), 32'(ld_rsp_ldq_idx), i - 1);
        end
        cyc();
        ld_vld = 1'b0; st_vld = 1'b0; dc_rsp_vld = 1'b1; dc_rsp_data = 32'h900;
        #1;
        chk("t2_last_rsp_vld", 32'(ld_rsp_vld), 1);
        chk("t2_last_rsp_idx", 32'(ld_rsp_ldq_idx), 9);
        cyc();
        dc_rsp_vld = 1'b0;

        // drain mode
        cyc();
        sdq_count = 4'd6;
        for (int j = 0; j < 3; j++) begin
            cyc();
            ld_vld = 1'b1; st_vld = 1'b1; ld_ldq_idx = 4'd6; ld_addr = 32'h600;
            st_addr = 32'h100 + 32'(j * 4); st_data = 32'hDEAD0000 + 32'(j); st_be = 4'h3;
            #1;
            chk($sformatf("t3_st_rdy_%0d", j), 32'(st_rdy), 1);
            chk($sformatf("t3_ld_rdy_%0d", j), 32'(ld_rdy), 0);
            if (j > 0) begin
                chk($sformatf("t3_req_we_%0d", j), 32'(dc_req_we), 1);
                chk($sformatf("t3_req_addr_%0d", j), dc_req_addr, 32'h100 + 32'((j - 1) * 4));
                chk($sformatf("t3_req_wdata_%0d", j), dc_req_wdata, 32'hDEAD0000 + 32'(j - 1));
                chk($sformatf("t3_req_be_%0d", j), 32'(dc_req_be), 32'h3);
            end
        end
        cyc();
        sdq_count = 4'd2; st_addr = 32'h10C;
        #1 chk("t3_exit_cycle_st_rdy", 32'(st_rdy), 1);
        cyc();
        #1;
        chk("t3_normal_ld_rdy", 32'(ld_rdy), 1);
        chk("t3_normal_st_rdy", 32'(st_rdy), 0);
        cyc();
        ld_vld = 1'b0; st_vld = 1'b0; dc_rsp_vld = 1'b1; dc_rsp_data = 32'h66;
        #1;
        chk("t3_ld_req_addr", dc_req_addr, 32'h600);
        chk("t3_rsp_idx", 32'(ld_rsp_ldq_idx), 6);
        cyc();
        dc_rsp_vld = 1'b0;

        // back-pressure holds the slot
        cyc();
        st_vld = 1'b1; st_addr = 32'h200; st_data = 32'h1234; st_be = 4'hC;
        #1 chk("t4_st_rdy", 32'(st_rdy), 1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            dc_req_rdy = 1'b0; ld_vld = 1'b1; ld_ldq_idx = 4'd2; ld_addr = 32'h700;
            st_addr = 32'h300; st_data = 32'h5678;
            #1;
            chk($sformatf("t4_hold_vld_%0d", k), 32'(dc_req_vld), 1);
            chk($sformatf("t4_hold_addr_%0d", k), dc_req_addr, 32'h200);
            chk($sformatf("t4_hold_wdata_%0d", k), dc_req_wdata, 32'h1234);
            chk($sformatf("t4_hold_be_%0d", k), 32'(dc_req_be), 32'hC);
            chk($sformatf("t4_hold_ld_rdy_%0d", k), 32'(ld_rdy), 0);
            chk($sformatf("t4_hold_st_rdy_%0d", k), 32'(st_rdy), 0);
        end
        cyc();
        dc_req_rdy = 1'b1;
        #1 chk("t4_release_ld_rdy", 32'(ld_rdy), 1);
        cyc();
        ld_vld = 1'b0; st_vld = 1'b0; dc_rsp_vld = 1'b1; dc_rsp_data = 32'h22;
        #1;
        chk("t4_next_vld", 32'(dc_req_vld), 1);
        chk("t4_next_we", 32'(dc_req_we), 0);
        chk("t4_next_addr", dc_req_addr, 32'h700);
        chk("t4_rsp_idx", 32'(ld_rsp_ldq_idx), 2);
        cyc();
        dc_rsp_vld = 1'b0;

        // tag FIFO full
        cyc();
        ld_vld = 1'b1; ld_ldq_idx = 4'd3; ld_addr = 32'h30;
        #1 chk("t5_ld3_rdy", 32'(ld_rdy), 1);
        cyc();
        ld_ldq_idx = 4'd4; ld_addr = 32'h40;
        #1 chk("t5_ld4_rdy", 32'(ld_rdy), 1);
        cyc();
        ld_ldq_idx = 4'd5; ld_addr = 32'h50;
        #1 chk("t5_full_rdy_a", 32'(ld_rdy), 0);
        cyc();
        #1 chk("t5_full_rdy_b", 32'(ld_rdy), 0);
        cyc();
        dc_rsp_vld = 1'b1; dc_rsp_data = 32'h33;
        #1;
        chk("t5_rsp3_vld", 32'(ld_rsp_vld), 1);
        chk("t5_rsp3_idx", 32'(ld_rsp_ldq_idx), 3);
        chk("t5_ld5_rdy_on_pop", 32'(ld_rdy), 1);
        cyc();
        ld_vld = 1'b0; dc_rsp_data = 32'h44;
        #1 chk("t5_rsp4_idx", 32'(ld_rsp_ldq_idx), 4);
        cyc();
        dc_rsp_data = 32'h55;
        #1;
        chk("t5_rsp5_idx", 32'(ld_rsp_ldq_idx), 5);
        chk("t5_rsp5_data", ld_rsp_data, 32'h55);
        cyc();
        dc_rsp_vld = 1'b0;

        // flush kills outstanding loads
        cyc();
        ld_vld = 1'b1; ld_ldq_idx = 4'd7; ld_addr = 32'h70;
        #1 chk("t6_ld7_rdy", 32'(ld_rdy), 1);
        cyc();
        ld_ldq_idx = 4'd8; ld_addr = 32'h80;
        #1 chk("t6_ld8_rdy", 32'(ld_rdy), 1);
        cyc();
        flush = 1'b1; ld_ldq_idx = 4'd9; ld_addr = 32'h90;
        #1;
        chk("t6_flush_ld_rdy", 32'(ld_rdy), 0);
        chk("t6_slot_issues", 32'(dc_req_vld), 1);
        chk("t6_slot_addr", dc_req_addr, 32'h80);
        cyc();
        flush = 1'b0; ld_vld = 1'b0; dc_rsp_vld = 1'b1; dc_rsp_data = 32'h77;
        #1 chk("t6_rsp7_killed", 32'(ld_rsp_vld), 0);
        cyc();
        dc_rsp_data = 32'h88;
        #1 chk("t6_rsp8_killed", 32'(ld_rsp_vld), 0);
        cyc();
        dc_rsp_vld = 1'b0; ld_vld = 1'b1; ld_ldq_idx = 4'd10; ld_addr = 32'hA0;
        #1 chk("t6_ld10_rdy", 32'(ld_rdy), 1);
        cyc();
        ld_vld = 1'b0; flush = 1'b1; dc_rsp_vld = 1'b1; dc_rsp_data = 32'hAA;
        #1 chk("t6_pop_with_flush", 32'(ld_rsp_vld), 0);
        cyc();
        flush = 1'b0; dc_rsp_vld = 1'b0; ld_vld = 1'b1; ld_ldq_idx = 4'd9; ld_addr = 32'h90;
        #1 chk("t6_ld9_rdy", 32'(ld_rdy), 1);
        cyc();
        ld_vld = 1'b0; dc_rsp_vld = 1'b1; dc_rsp_data = 32'h99;
        #1;
        chk("t6_rsp9_vld", 32'(ld_rsp_vld), 1);
        chk("t6_rsp9_idx", 32'(ld_rsp_ldq_idx), 9);
        chk("t6_rsp9_data", ld_rsp_data, 32'h99);
        cyc();
        dc_rsp_vld = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_dcache_arbiter.md
Name: lsu_dcache_arbiter

Overview:
Shares the single D-cache request port between load issue from the load data queue and store drain from the store data queue. Selects one request per cycle and registers it onto the cache port. Tracks outstanding loads in order, so cache responses route back with their LDQ index. Applies store-drain pressure and a starvation guard, and discards in-flight load data on a pipeline flush.

Parameters:
LDQ_IDX_W, 4, width of LDQ index (log2 of LDQ_ENTRIES)
SDQ_CNT_W, 4, width of SDQ occupancy count
DRAIN_HI, 6, sdq_count at or above which DRAIN mode is entered
DRAIN_LO, 2, sdq_count at or below which DRAIN mode exits
STARVE_LIMIT, 8, cycles a valid store may lose before one store is forced
MAX_OUTST, 2, max loads awaiting response (tag FIFO depth)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld_vld  in  1  load request valid
ld_rdy  out  1  load request accepted this cycle
ld_ldq_idx  in  LDQ_IDX_W  LDQ entry of the load
ld_addr  in  32  load byte address
st_vld  in  1  store drain request valid
st_rdy  out  1  store accepted this cycle
st_addr  in  32  store address
st_data  in  32  store data
st_be  in  4  store byte enables
sdq_count  in  SDQ_CNT_W  current SDQ occupancy
flush  in  1  kill all outstanding and pending loads
dc_req_vld  out  1  cache request valid
dc_req_rdy  in  1  cache accepts request
dc_req_we  out  1  1=store, 0=load
dc_req_addr  out  32  request address
dc_req_wdata  out  32  store data (0 for loads)
dc_req_be  out  4  byte enables (4'hF for loads)
dc_rsp_vld  in  1  load response valid (in order; stores give no response)
dc_rsp_data  in  32  load response data
ld_rsp_vld  out  1  load data return valid
ld_rsp_ldq_idx  out  LDQ_IDX_W  LDQ entry of returned data
ld_rsp_data  out  32  returned data

Behaviour:
- Reset (async, rst_n=0): dc_req_vld=0, all dc_req_* fields 0, mode=NORMAL, starve_cnt=0, tag FIFO empty, all kill bits cleared. ld_rdy, st_rdy and ld_rsp_vld are 0 while in reset. Reset mid-transaction drops everything.
- Output register "slot": can load a new request when dc_req_vld=0 or dc_req_rdy=1. Accepted request appears on dc_req_* the next cycle. Fields hold stable while dc_req_vld && !dc_req_rdy. Throughput is 1 request/cycle.
- load_ok = slot free && !flush && (fifo_cnt<MAX_OUTST || pop this cycle).
- store_ok = slot free.
- Mode FSM:
  - NORMAL -> DRAIN when sdq_count>=DRAIN_HI.
  - DRAIN -> NORMAL when sdq_count<=DRAIN_LO.
- Priority:
  - NORMAL: load wins, except store wins when starve_cnt==STARVE_LIMIT.
  - DRAIN: store wins.
  - A loser with ok=1 gets nothing that cycle; ld_rdy/st_rdy are combinational and at most one is 1.
- starve_cnt:
  - +1 (saturating) each cycle st_vld && !st_rdy in NORMAL.
  - Cleared on any store accept or on entering DRAIN.
- Load accept pushes {ld_ldq_idx, kill=0} into the tag FIFO. Store accept pushes nothing.
- dc_rsp_vld pops the FIFO head:
  - ld_rsp_vld = dc_rsp_vld && !head.kill (same cycle, combinational).
  - ld_rsp_ldq_idx = head idx; ld_rsp_data = dc_rsp_data.
  - dc_rsp_vld with an empty FIFO is ignored (bench asserts it never happens).
- flush:
  - Sets kill on every valid FIFO entry, including one popped the same cycle, so its ld_rsp_vld=0.
  - Also forces ld_rdy=0 that cycle.
  - A load already in the slot still issues; its entry is killed.
  - Stores are unaffected.
- FIFO pointers wrap modulo MAX_OUTST. Simultaneous push+pop on a full FIFO is legal and leaves the count unchanged.

Test Plan:
- After reset, ld_vld=1 idx=15 addr=5108, dc_req_rdy=1 -> ld_rdy=1. Next cycle dc_req_vld=1, we=0, addr=5108, be=F. dc_rsp_vld data=0xCAFE -> ld_rsp_vld=1, idx=15, data=0xCAFE.
- ld_vld and st_vld held, sdq_count=1 -> loads granted for 8 cycles; 9th cycle st_rdy=1, ld_rdy=0; starve_cnt returns to 0.
- sdq_count=6 with both valid -> store granted each cycle until sdq_count=2, then loads resume.
- dc_req_rdy=0 for 3 cycles after a store accept -> dc_req_* unchanged, ld_rdy=st_rdy=0. Release -> next request issues the following cycle.
- Issue loads idx 3, 4 (FIFO full) -> ld_rdy=0 for idx 5 until the first response. That response returns idx 3; idx 5 is accepted the same cycle.
- Loads idx 7, 8 outstanding, flush=1 -> both responses give ld_rsp_vld=0. A load idx 9 issued after the flush returns with ld_rsp_vld=1.
